// File: rtl/mouse_master_sm_if.sv
// Signal bundle between the PS/2 mouse control FSM and its neighbours.
// master: FSM side (drives commands, packets); slave: PHY/system side.
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic       INIT_DONE;

  modport master (
    output SEND_BYTE,
    output BYTE_TO_SEND,
    input  BYTE_SENT,
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY,
    output MOUSE_STATUS,
    output MOUSE_DX,
    output MOUSE_DY,
    output SEND_INTERRUPT,
    output INIT_DONE
  );

  modport slave (
    input  SEND_BYTE,
    input  BYTE_TO_SEND,
    output BYTE_SENT,
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY,
    input  MOUSE_STATUS,
    input  MOUSE_DX,
    input  MOUSE_DY,
    input  SEND_INTERRUPT,
    input  INIT_DONE
  );
endinterface

// File: rtl/mouse_master_sm.sv
// PS/2 mouse init sequencer and 3-byte movement packet assembler.
// Ports: CLK, RESET_N (async, active low), bus (mouse_master_sm_if.master):
//   tx: SEND_BYTE/BYTE_TO_SEND out, BYTE_SENT in
//   rx: READ_ENABLE out, BYTE_READ/BYTE_ERROR_CODE/BYTE_READY in
//   sys: MOUSE_STATUS/DX/DY, SEND_INTERRUPT, INIT_DONE out
// Optional macro PACKET_SYNC_CHECK_EN: byte-1 bit-3 resync and
// overflow masking of dX/dY.
module mouse_master_sm #(
  parameter int POWERUP_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int CNT_W          = 24
) (
  input logic              CLK,
  input logic              RESET_N,
  mouse_master_sm_if.master bus
);

  typedef enum logic [3:0] {
    POWERUP_WAIT,
    SEND_RESET,
    WAIT_SENT_RESET,
    WAIT_ACK,
    WAIT_SELFTEST,
    WAIT_ID,
    SEND_ENABLE,
    WAIT_SENT_ENABLE,
    WAIT_ACK_ENABLE,
    STREAM_B1,
    STREAM_B2,
    STREAM_B3
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST =
    CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_TEST   = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;

  logic       send_q;
  logic [7:0] tx_byte_q;
  logic       rd_en_q;
  logic [7:0] status_r;
  logic [7:0] dx_r;
  logic [7:0] st_q;
  logic [7:0] dx_q;
  logic [7:0] dy_q;
  logic       irq_q;
  logic       done_q;

  logic rx_ok;
  logic rx_bad;
  logic tmo;
  logic lat_st;
  logic lat_dx;
  logic publish;
  logic ovf;

  function automatic logic is_rx(state_t s);
    return s inside {WAIT_ACK, WAIT_SELFTEST, WAIT_ID,
                     WAIT_ACK_ENABLE, STREAM_B1,
                     STREAM_B2, STREAM_B3};
  endfunction

  function automatic logic is_stream(state_t s);
    return s inside {STREAM_B1, STREAM_B2, STREAM_B3};
  endfunction

  // Expect state: any strobe either advances on the right
  // error-free byte or restarts; silence times out.
  function automatic state_t expect_nx(
    state_t     cur,
    state_t     ok_nx,
    logic       rdy,
    logic       ok,
    logic [7:0] got,
    logic [7:0] want,
    logic       to
  );
    if (rdy)
      return (ok && got == want) ? ok_nx : SEND_RESET;
    if (to)
      return SEND_RESET;
    return cur;
  endfunction

  assign rx_ok  = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'd0);
  assign rx_bad = bus.BYTE_READY && (bus.BYTE_ERROR_CODE != 2'd0);
  assign tmo    = (cnt == TO_LAST);

  always_comb begin
    state_n = state;
    lat_st  = 1'b0;
    lat_dx  = 1'b0;
    publish = 1'b0;
    unique case (state)
      POWERUP_WAIT:
        if (cnt == PWR_LAST) state_n = SEND_RESET;
      SEND_RESET:
        state_n = WAIT_SENT_RESET;
      WAIT_SENT_RESET:
        if (bus.BYTE_SENT) state_n = WAIT_ACK;
        else if (tmo)      state_n = SEND_RESET;
      WAIT_ACK:
        state_n = expect_nx(state, WAIT_SELFTEST,
          bus.BYTE_READY, rx_ok, bus.BYTE_READ, RSP_ACK, tmo);
      WAIT_SELFTEST:
        state_n = expect_nx(state, WAIT_ID,
          bus.BYTE_READY, rx_ok, bus.BYTE_READ, RSP_TEST, tmo);
      WAIT_ID:
        state_n = expect_nx(state, SEND_ENABLE,
          bus.BYTE_READY, rx_ok, bus.BYTE_READ, RSP_ID, tmo);
      SEND_ENABLE:
        state_n = WAIT_SENT_ENABLE;
      WAIT_SENT_ENABLE:
        if (bus.BYTE_SENT) state_n = WAIT_ACK_ENABLE;
        else if (tmo)      state_n = SEND_RESET;
      WAIT_ACK_ENABLE:
        state_n = expect_nx(state, STREAM_B1,
          bus.BYTE_READY, rx_ok, bus.BYTE_READ, RSP_ACK, tmo);
      STREAM_B1: begin
`ifdef PACKET_SYNC_CHECK_EN
        // bit 3 is always set in a status byte; drop until aligned
        if (rx_ok && bus.BYTE_READ[3]) begin
`else
        if (rx_ok) begin
`endif
          lat_st  = 1'b1;
          state_n = STREAM_B2;
        end
      end
      STREAM_B2:
        if (rx_ok) begin
          lat_dx  = 1'b1;
          state_n = STREAM_B3;
        end else if (rx_bad) begin
          state_n = STREAM_B1;
        end
      STREAM_B3:
        if (rx_ok) begin
          publish = 1'b1;
          state_n = STREAM_B1;
        end else if (rx_bad) begin
          state_n = STREAM_B1;
        end
      default:
        state_n = POWERUP_WAIT;
    endcase
  end

`ifdef PACKET_SYNC_CHECK_EN
  assign ovf = status_r[7] | status_r[6];
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= POWERUP_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || is_stream(state_n))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they line
  // up with the state they describe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      send_q    <= 1'b0;
      tx_byte_q <= 8'h00;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
      status_r  <= 8'h00;
      dx_r      <= 8'h00;
      st_q      <= 8'h00;
      dx_q      <= 8'h00;
      dy_q      <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      send_q  <= (state_n == SEND_RESET) ||
                 (state_n == SEND_ENABLE);
      rd_en_q <= is_rx(state_n);
      done_q  <= is_stream(state_n);
      irq_q   <= publish;
      if (state_n == SEND_RESET)
        tx_byte_q <= CMD_RESET;
      else if (state_n == SEND_ENABLE)
        tx_byte_q <= CMD_ENABLE;
      if (lat_st) status_r <= bus.BYTE_READ;
      if (lat_dx) dx_r     <= bus.BYTE_READ;
      if (publish) begin
        st_q <= status_r;
        dx_q <= ovf ? 8'h00 : dx_r;
        dy_q <= ovf ? 8'h00 : bus.BYTE_READ;
      end
    end
  end

  assign bus.SEND_BYTE      = send_q;
  assign bus.BYTE_TO_SEND   = tx_byte_q;
  assign bus.READ_ENABLE    = rd_en_q;
  assign bus.MOUSE_STATUS   = st_q;
  assign bus.MOUSE_DX       = dx_q;
  assign bus.MOUSE_DY       = dy_q;
  assign bus.SEND_INTERRUPT = irq_q;
  assign bus.INIT_DONE      = done_q;

endmodule
